// File: rtl/sqrt_sig_square_iter_pkg.sv
// sqrt_sig_square_iter_pkg: shared sizes, result packing and FSM states for the significand squarer.
package sqrt_sig_square_iter_pkg;
   localparam int SIG_WIDTH = 23;
   localparam int WIDTH     = SIG_WIDTH + 1;
   localparam int PWIDTH    = 2 * WIDTH;
   localparam int CNT_W     = $clog2(WIDTH);

   typedef struct packed {
      logic                 hidden;
      logic [SIG_WIDTH-1:0] frac;
      logic                 guard;
      logic                 sticky;
   } z_sig_t;

   typedef enum logic [1:0] {
      SQ_IDLE,
      SQ_BUSY,
      SQ_DONE
   } sq_state_t;
endpackage

// File: rtl/BKA.sv
// BKA: Brent-Kung parallel-prefix adder, carry-in 0, carry-out dropped.
module BKA #(
   parameter int width = 48
) (
   input  logic [width-1:0] i_a,
   input  logic [width-1:0] i_b,
   output logic [width-1:0] o_s
);
   localparam int LV = $clog2(width);

   logic [width-1:0] w_g0, w_p0, w_c;
   logic             w_unused;

   assign w_g0 = i_a & i_b;
   assign w_p0 = i_a ^ i_b;

   // First LV levels build power-of-two spans upward, the last LV fill the gaps back down.
   for (genvar l = 0; l < 2 * LV; l++) begin : g_lvl
      localparam int S = (l < LV) ? l : 2 * LV - 1 - l;
      localparam int D = 1 << S;
      logic [width-1:0] w_gi, w_pi, w_go, w_po;
      if (l == 0) begin : g_src
         assign w_gi = w_g0;
         assign w_pi = w_p0;
      end else begin : g_src
         assign w_gi = g_lvl[l-1].w_go;
         assign w_pi = g_lvl[l-1].w_po;
      end
      for (genvar i = 0; i < width; i++) begin : g_bit
         localparam bit C = (l < LV) ? ((i + 1) % (2 * D) == 0)
                                     : (i >= 2 * D && (i + 1) % (2 * D) == D);
         if (C) begin : g_op
            assign w_go[i] = w_gi[i] | (w_pi[i] & w_gi[i-D]);
            assign w_po[i] = w_pi[i] & w_pi[i-D];
         end else begin : g_pass
            assign w_go[i] = w_gi[i];
            assign w_po[i] = w_pi[i];
         end
      end
   end

   assign w_c      = g_lvl[2*LV-1].w_go;
   assign o_s      = w_p0 ^ {w_c[width-2:0], 1'b0};
   assign w_unused = ^{g_lvl[2*LV-1].w_po, w_c[width-1]};
endmodule

// File: rtl/sqrt_sig_square_iter.sv
// sqrt_sig_square_iter: iterative shift-add significand squarer emitting the
// unrounded {hidden, frac, guard, sticky} square plus an exponent-increment flag.
module sqrt_sig_square_iter
   import sqrt_sig_square_iter_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SIG_WIDTH-1:0] a_sig,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SIG_WIDTH+2:0] z_sig_nr,
   output logic                 exp_inc
);
   sq_state_t         r_state, w_next;
   logic [WIDTH-1:0]  r_m;
   logic [PWIDTH-1:0] r_acc, w_addend, w_sum;
   logic [CNT_W-1:0]  r_cnt;
   z_sig_t            r_z, w_norm;
   logic              r_exp_inc, w_last, w_accept;

   assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
   assign w_accept = enable & in_valid & (r_state == SQ_IDLE);
   assign w_addend = r_m[r_cnt] ? {{WIDTH{1'b0}}, r_m} << r_cnt : '0;

   BKA #(.width(PWIDTH)) u_bka (
      .i_a (r_acc),
      .i_b (w_addend),
      .o_s (w_sum)
   );

   // Top product bit tells whether the square landed in [2,4) or [1,2).
   assign w_norm = w_sum[PWIDTH-1] ? {w_sum[PWIDTH-1:WIDTH-1], |w_sum[WIDTH-2:0]}
                                   : {w_sum[PWIDTH-2:WIDTH-2], |w_sum[WIDTH-3:0]};

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_state <= SQ_IDLE;
      else         r_state <= w_next;

   always_comb begin
      w_next    = r_state;
      in_ready  = r_state == SQ_IDLE;
      out_valid = r_state == SQ_DONE;
      if (enable)
         case (r_state)
            SQ_IDLE: w_next = in_valid ? SQ_BUSY : SQ_IDLE;
            SQ_BUSY: w_next = w_last ? SQ_DONE : SQ_BUSY;
            SQ_DONE: w_next = out_ready ? SQ_IDLE : SQ_DONE;
            default: w_next = SQ_IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_m       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_z       <= '0;
         r_exp_inc <= 1'b0;
      end else if (w_accept) begin
         r_m   <= {1'b1, a_sig};
         r_acc <= '0;
         r_cnt <= '0;
      end else if (enable && r_state == SQ_BUSY) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_z       <= w_norm;
            r_exp_inc <= w_sum[PWIDTH-1];
         end
      end

   assign z_sig_nr = r_z;
   assign exp_inc  = r_exp_inc;
endmodule

// File: doc/sqrt_sig_square_iter.md
# sqrt_sig_square_iter

Iterative significand squarer: the inverse datapath of the non-restoring square-root significand stage. It accepts a single-precision-style significand (hidden bit implied), computes the exact square with one shift-add step per cycle, then normalizes and emits it. The output uses the same `{hidden, fraction, guard, sticky}` packing the sqrt path produces, so the shared FP rounding stage consumes it unchanged. It sits in the FP square/multiply path and also serves as a sqrt-verification companion (`sqrt(x)^2` round-trip).

## Interface
- `sig_width`, 23: stored fraction bits. `width = sig_width+1` is the significand including the hidden bit.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: global clock-enable. When low, all state holds and no handshake completes.
- `in_valid` in 1: the input operand is valid.
- `in_ready` out 1: the block can accept an operand.
- `a_sig` in `sig_width`: fraction of the operand, without the hidden bit.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `z_sig_nr` out `sig_width+3`: `{hidden, fraction[sig_width], guard, sticky}` of the normalized square, unrounded.
- `exp_inc` out 1: the square is ≥ 2.0. The caller adds 1 to the doubled exponent.

## Operation
- Operand: `m = {1'b1, a_sig}` (`width` bits). Exact product `P = m*m` (`2*width` bits).
- FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid & enable`: latch `m`, clear the accumulator, set the bit counter `i = 0`, and go to BUSY.
- **BUSY**
  - Runs `width` iterations. In iteration `i`, if `m[i] = 1` then `acc += m << i`.
  - After the iteration with `i = width-1`, go to DONE.
  - `in_ready = 0`.
- **DONE**
  - `out_valid = 1`. Outputs are registered and stable.
  - On `out_ready & enable`: go to IDLE.
  - There is no IDLE bypass.
- Normalization (registered on entry to DONE):
  - If `P[2w-1] = 1`: `exp_inc = 1`, `z_sig_nr = {P[2w-1:w-1], |P[w-2:0]}`.
  - Otherwise: `exp_inc = 0`, `z_sig_nr = {P[2w-2:w-2], |P[w-3:0]}`.
  - `z_sig_nr` MSB is always 1 (`P ≥ 2^(2w-2)`).
- Accumulator is `2*width` bits with no overflow (`P < 2^(2w)`). The adder is `2*width` wide; carry-out is ignored.
- `a_sig` is sampled only at acceptance. Changes afterwards have no effect.

## Timing
- Reset (async, any state, including mid-BUSY):
  - State goes to IDLE. The accumulator, counter, `z_sig_nr` and `exp_inc` go to 0. `out_valid` goes to 0.
  - `in_ready` is 1 after reset.
  - An in-flight operation is discarded.
- Latency: the operand is accepted at edge T. `out_valid` rises after edge T+`width` (24 enabled cycles for `sig_width=23`).
- Throughput: one result per `width+2` enabled cycles at best (accept, `width` iterations, one DONE cycle).
- `enable = 0` freezes the FSM, counter, accumulator and outputs. Latency is counted in enabled cycles only.
- `out_valid` stays high and `z_sig_nr` stays stable while `out_ready = 0`, for an unbounded time.
- `in_valid` during BUSY or DONE is ignored. The upstream block must hold it until `in_ready`.
- `out_valid` and `in_ready` are never high together.

## Structure
- Shared FP package holds:
  - the `width` and `2*width` localparams,
  - the `{hidden, frac, guard, sticky}` packed struct,
  - the FSM state enum (`SQ_IDLE`, `SQ_BUSY`, `SQ_DONE`).
- One sub-module: `BKA #(.width(2*width))` for the accumulate adder (`acc + (m[i] ? m<<i : 0)`).
- The normalizer is inline combinational logic feeding the output registers.
- The counter is `$clog2(width)` bits.

## Test plan
- `a_sig = 0x000000` -> after 24 enabled cycles, `z_sig_nr = 0x2000000`, `exp_inc = 0`.
- `a_sig = 0x400000` (1.5) -> `z_sig_nr = 0x2400000`, `exp_inc = 1` (2.25 = 1.125·2).
- `a_sig = 0x7FFFFF` -> `z_sig_nr = 0x3FFFFF9` (sticky = 1), `exp_inc = 1`.
- Backpressure: hold `out_ready = 0` for 10 cycles in DONE -> `out_valid` and `z_sig_nr` stable, `in_ready = 0`. Then `out_ready = 1` -> IDLE next cycle and `in_ready = 1`.
- `enable` toggled low for 5 cycles mid-BUSY -> result unchanged, `out_valid` delayed exactly 5 cycles.
- `resetn` asserted mid-BUSY -> all outputs 0 immediately and `in_ready = 1`. A new operand `0x400000` then completes with correct results.
- Random operands (10k) -> `z_sig_nr` and `exp_inc` match a reference model of exact `m*m`.
